// File: rtl/keypad_number_entry.sv
// keypad_number_entry: builds a signed operand from keypad key events (optional idle timeout via NUM_ENTRY_TIMEOUT_EN)
module keypad_number_entry #(
  parameter int MAX_DIGITS = 4,
  parameter int WIDTH = 16
`ifdef NUM_ENTRY_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 5000
`endif
) (
  input  logic                    clk_div,
  input  logic                    rst,
  input  logic [3:0]              num,
  input  logic                    load_num,
  output logic [WIDTH-1:0]        result,
  output logic                    result_valid,
  output logic [4*MAX_DIGITS-1:0] entry_bcd,
  output logic [2:0]              entry_count,
  output logic                    entry_neg,
  output logic                    digit_drop
);
  localparam int BW = 4*MAX_DIGITS;
  typedef enum logic [1:0] {IDLE, ENTRY, DONE} state_t;
  state_t state, state_n;
  logic [BW-1:0] bcd_n;
  logic [2:0] count_n;
  logic neg_n, valid_n, drop_n, clr, timeout;
  logic [WIDTH-1:0] mag, mag_n, result_n;
`ifdef NUM_ENTRY_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt;
  always_ff @(posedge clk_div)
    if (rst || load_num || state != ENTRY) idle_cnt <= '0;
    else idle_cnt <= idle_cnt + 1'b1;
  assign timeout = !load_num && state == ENTRY && idle_cnt == TW'(TIMEOUT_CYCLES - 1);
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_n = state;
    bcd_n = entry_bcd;
    count_n = entry_count;
    neg_n = entry_neg;
    mag_n = mag;
    result_n = result;
    valid_n = 1'b0;
    drop_n = 1'b0;
    clr = 1'b0;
    if (load_num) begin
      if (num <= 4'd9) begin
        if (state != ENTRY) begin
          bcd_n = BW'(num);
          count_n = 3'd1;
          mag_n = WIDTH'(num);
          state_n = ENTRY;
        end else if (entry_count < 3'(MAX_DIGITS)) begin
          bcd_n = (entry_bcd << 4) | BW'(num);
          count_n = entry_count + 3'd1;
          mag_n = (mag << 3) + (mag << 1) + WIDTH'(num);
        end else drop_n = 1'b1;
      end else if (num == 4'hA) begin
        // digits are already empty in IDLE/DONE, so a plain toggle covers every state
        neg_n = !entry_neg;
        state_n = ENTRY;
      end else if (num == 4'hB) begin
        if (state == ENTRY && entry_count != 3'd0) begin
          result_n = entry_neg ? -mag : mag;
          valid_n = 1'b1;
          clr = 1'b1;
          state_n = DONE;
        end
      end else if (num == 4'hC) begin
        clr = 1'b1;
        state_n = IDLE;
      end
    end else if (timeout) begin
      clr = 1'b1;
      state_n = IDLE;
    end
    if (clr) begin
      bcd_n = '0;
      count_n = 3'd0;
      neg_n = 1'b0;
      mag_n = '0;
    end
  end
  always_ff @(posedge clk_div)
    if (rst) begin
      state <= IDLE;
      entry_bcd <= '0;
      entry_count <= 3'd0;
      entry_neg <= 1'b0;
      mag <= '0;
      result <= '0;
      result_valid <= 1'b0;
      digit_drop <= 1'b0;
    end else begin
      state <= state_n;
      entry_bcd <= bcd_n;
      entry_count <= count_n;
      entry_neg <= neg_n;
      mag <= mag_n;
      result <= result_n;
      result_valid <= valid_n;
      digit_drop <= drop_n;
    end
endmodule
